// File: rtl/shift_counter_pkg.sv
// Shared encodings and start-state helpers for the ring/Johnson shift counter.
// Latency: n/a (package of types and constant functions only).
// Backpressure: n/a; optional legality check in the counter is gated by SHIFT_CNT_SELFCORRECT_EN.
package shift_counter_pkg;

   // Widest counter supported; start-state helpers return this many bits and
   // callers size-cast down to their own WIDTH.
   localparam int MAX_WIDTH = 32;

   typedef enum logic {
      MODE_RING    = 1'b0,
      MODE_JOHNSON = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,   // shift toward MSB
      DIR_DOWN = 1'b1    // shift toward LSB
   } dir_e;

   // What the counter does on a given edge (reset is handled separately,
   // directly inside the state register).
   typedef enum logic [2:0] {
      ACT_LOAD    = 3'd0,
      ACT_REINIT  = 3'd1,
      ACT_CORRECT = 3'd2,
      ACT_SHIFT   = 3'd3,
      ACT_HOLD    = 3'd4
   } act_e;

   // Ring counters start with a single one in bit 0.
   function automatic logic [MAX_WIDTH-1:0] ring_start();
      return {{(MAX_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Johnson counters start all-zeros.
   function automatic logic [MAX_WIDTH-1:0] johnson_start();
      return '0;
   endfunction

   // Start state for whichever mode is selected.
   function automatic logic [MAX_WIDTH-1:0] start_state(input logic mode);
      return (mode == MODE_JOHNSON) ? johnson_start() : ring_start();
   endfunction

endpackage

// File: rtl/shift_cnt_legal_chk.sv
// Combinational legality check of a ring (one-hot) or Johnson (<=1 edge) state.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; used only when SHIFT_CNT_SELFCORRECT_EN is defined.
module shift_cnt_legal_chk
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic             mode,
   output logic             legal
);

   logic one_hot;
   logic few_edges;

   // Ring states carry exactly one set bit; Johnson states have at most one
   // boundary between a run of ones and a run of zeros (not wrapping around).
   always_comb begin
      one_hot   = ($countones(q) == 1);
      few_edges = ($countones(q[WIDTH-1:1] ^ q[WIDTH-2:0]) <= 1);
      legal     = (mode == MODE_RING) ? one_hot : few_edges;
   end

endmodule

// File: rtl/shift_counter_gen.sv
// Ring / Johnson shift counter with load, direction control and wrap/err pulses.
// Latency: 1 cycle from inputs to q/wrap/err (all registered); macro SHIFT_CNT_SELFCORRECT_EN enables auto-correction.
// Backpressure: none; en low holds state, load/mode change/correction override shifting.
module shift_counter_gen
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4   // legal range 2..32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             err
);

   logic             mode_q;
   logic [WIDTH-1:0] start_cur;
   logic [WIDTH-1:0] shifted;
   logic             illegal;
   act_e             act;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;

   // The start state always follows the live mode input, so reset and
   // re-initialisation land in the state of the mode being switched to.
   assign start_cur = WIDTH'(start_state(mode));

`ifdef SHIFT_CNT_SELFCORRECT_EN
   logic legal;

   shift_cnt_legal_chk #(
      .WIDTH (WIDTH)
   ) u_legal_chk (
      .q     (q),
      .mode  (mode),
      .legal (legal)
   );

   assign illegal = ~legal;
`else
   // Without the checker every state is treated as legal and simply keeps
   // rotating/twisting.
   assign illegal = 1'b0;
`endif

   // One shift step: ring feeds the outgoing bit back in, Johnson feeds it
   // back inverted.
   always_comb begin
      shifted = q;
      case ({mode, dir})
         {MODE_RING,    DIR_UP}:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
         {MODE_RING,    DIR_DOWN}: shifted = {q[0], q[WIDTH-1:1]};
         {MODE_JOHNSON, DIR_UP}:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
         {MODE_JOHNSON, DIR_DOWN}: shifted = {~q[0], q[WIDTH-1:1]};
         default:                  shifted = q;
      endcase
   end

   // Pick the single action for this edge in priority order:
   // load > mode change > illegal-state correction > shift > hold.
   always_comb begin
      act = ACT_HOLD;
      if (load) begin
         act = ACT_LOAD;
      end else if (mode != mode_q) begin
         act = ACT_REINIT;
      end else if (illegal) begin
         act = ACT_CORRECT;
      end else if (en) begin
         act = ACT_SHIFT;
      end
   end

   // Next q and wrap for the chosen action; wrap only ever follows a real
   // shift that lands on the start state.
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      case (act)
         ACT_LOAD:    q_nxt = load_val;
         ACT_REINIT:  q_nxt = start_cur;
         ACT_CORRECT: q_nxt = start_cur;
         ACT_SHIFT: begin
            q_nxt    = shifted;
            wrap_nxt = (shifted == start_cur);
         end
         default:     q_nxt = q;
      endcase
   end

   // State register; reset beats everything else on the same edge, and
   // mode_q tracks mode on every edge so a change is seen exactly once.
   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= start_cur;
         wrap   <= 1'b0;
         mode_q <= mode;
      end else begin
         q      <= q_nxt;
         wrap   <= wrap_nxt;
         mode_q <= mode;
      end
   end

`ifdef SHIFT_CNT_SELFCORRECT_EN
   // err is a one-cycle pulse marking the edge that repaired an illegal state.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else begin
         err <= (act == ACT_CORRECT);
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_counter_gen.sv
// Randomized and directed stimulus for shift_counter_gen against a behavioural model.
// Latency: expectations are queued when inputs are driven and popped one cycle later.
// Backpressure: none; the monitor pops one entry per clock while the queue is non-empty.
module tb_shift_counter_gen;

   localparam int          W    = 4;
   localparam int unsigned MASK = (1 << W) - 1;
`ifdef SHIFT_CNT_SELFCORRECT_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, en, mode, dir, load;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic         wrap, err;

   always #5 clk = ~clk;

   shift_counter_gen #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .wrap     (wrap),
      .err      (err)
   );

   typedef struct {
      logic [W-1:0] q;
      logic         wrap;
      logic         err;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   int unsigned m_q      = 0;
   logic        m_mode_q = 1'b0;

   function automatic int unsigned start_of(input logic m);
      return m ? 0 : 1;
   endfunction

   // Bit leaving the register is fed back at the other end, inverted in Johnson mode.
   function automatic int unsigned shift_of(input int unsigned v, input logic m, input logic d);
      int unsigned fb;
      fb = d ? (v & 1) : ((v >> (W - 1)) & 1);
      if (m) fb = fb ^ 1;
      if (!d) return ((v << 1) | fb) & MASK;
      return (v >> 1) | (fb << (W - 1));
   endfunction

   function automatic bit legal_of(input int unsigned v, input logic m);
      int ones;
      int edges;
      ones  = 0;
      edges = 0;
      for (int i = 0; i < W; i++) ones += int'((v >> i) & 1);
      for (int i = 0; i < W - 1; i++)
         if (((v >> i) & 1) != ((v >> (i + 1)) & 1)) edges++;
      return m ? (edges <= 1) : (ones == 1);
   endfunction

   // Drive one edge worth of inputs, advance the model, and queue the expectation
   // (the literal one for directed steps, the model's otherwise).
   task automatic drive(input logic r, input logic e, input logic m, input logic d,
                        input logic l, input logic [W-1:0] lv, input string nm,
                        input bit directed, input logic [W-1:0] dq,
                        input logic dw, input logic de);
      int unsigned nq;
      logic        nw;
      logic        ne;
      exp_t        x;
      @(negedge clk);
      rst = r; en = e; mode = m; dir = d; load = l; load_val = lv;
      nw = 1'b0;
      ne = 1'b0;
      if (r)                             nq = start_of(m);
      else if (l)                        nq = int'(lv);
      else if (m != m_mode_q)            nq = start_of(m);
      else if (SC && !legal_of(m_q, m)) begin nq = start_of(m); ne = 1'b1; end
      else if (e) begin
         nq = shift_of(m_q, m, d);
         nw = (nq == start_of(m));
      end
      else                               nq = m_q;
      m_q      = nq;
      m_mode_q = m;
      x.name = nm;
      if (directed) begin
         x.q = dq; x.wrap = dw; x.err = de;
      end else begin
         x.q = W'(nq); x.wrap = nw; x.err = ne;
      end
      sb.push_back(x);
   endtask

   task automatic chk(input logic r, input logic e, input logic m, input logic d,
                      input logic l, input logic [W-1:0] lv, input string nm,
                      input logic [W-1:0] dq, input logic dw, input logic de);
      drive(r, e, m, d, l, lv, nm, 1'b1, dq, dw, de);
   endtask

   // Monitor: compares the DUT to the oldest queued expectation once per cycle.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (q !== x.q) begin
               errors++;
               $display("FAIL %s q: got %b expected %b", x.name, q, x.q);
            end
            checks++;
            if (wrap !== x.wrap) begin
               errors++;
               $display("FAIL %s wrap: got %b expected %b", x.name, wrap, x.wrap);
            end
            checks++;
            if (err !== x.err) begin
               errors++;
               $display("FAIL %s err: got %b expected %b", x.name, err, x.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rseq [4];
      logic [W-1:0] jseq [8];
      logic         cur_mode;
      int           t;
      rseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      jseq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

      // Reset and one full ring period
      chk(1, 0, 0, 0, 0, 4'b0000, "reset", 4'b0001, 0, 0);
      for (int i = 0; i < 4; i++)
         chk(0, 1, 0, 0, 0, 4'b0000, "ring", rseq[i], (i == 3), 0);

      // Direction change without reinitialisation
      chk(0, 1, 0, 0, 0, 4'b0000, "dir_pre", 4'b0010, 0, 0);
      chk(0, 1, 0, 0, 0, 4'b0000, "dir_pre", 4'b0100, 0, 0);
      chk(0, 1, 0, 1, 0, 4'b0000, "dir_down", 4'b0010, 0, 0);
      chk(0, 1, 0, 1, 0, 4'b0000, "dir_down", 4'b0001, 1, 0);
      chk(0, 1, 0, 1, 0, 4'b0000, "dir_down", 4'b1000, 0, 0);

      // Hold with en low
      chk(0, 0, 0, 1, 0, 4'b0000, "hold", 4'b1000, 0, 0);
      chk(0, 0, 0, 0, 0, 4'b0000, "hold", 4'b1000, 0, 0);

      // Reset beats load and a wrapping shift on the same edge
      chk(1, 1, 0, 0, 1, 4'b1111, "rst_prio", 4'b0001, 0, 0);

      // Johnson: two full periods, wrap every 8
      chk(1, 0, 1, 0, 0, 4'b0000, "j_reset", 4'b0000, 0, 0);
      for (int i = 0; i < 16; i++)
         chk(0, 1, 1, 0, 0, 4'b0000, "johnson", jseq[i % 8], ((i % 8) == 7), 0);

      // Mode change reinitialises with no shift and no wrap
      for (int i = 0; i < 3; i++)
         chk(0, 1, 1, 0, 0, 4'b0000, "j_pre", jseq[i], 0, 0);
      chk(0, 1, 0, 0, 0, 4'b0000, "mode_chg", 4'b0001, 0, 0);
      chk(0, 1, 1, 0, 0, 4'b0000, "mode_back", 4'b0000, 0, 0);
      for (int i = 0; i < 3; i++)
         chk(0, 1, 1, 0, 0, 4'b0000, "j_pre2", jseq[i], 0, 0);
      chk(0, 1, 0, 0, 1, 4'b1010, "mode_load", 4'b1010, 0, 0);

      // Illegal ring state: corrected (with checker) or rotated (without)
      chk(0, 1, 0, 0, 1, 4'b0110, "load", 4'b0110, 0, 0);
      chk(0, 1, 0, 0, 0, 4'b0000, "illegal1", SC ? 4'b0001 : 4'b1100, 0, SC);
      chk(0, 1, 0, 0, 0, 4'b0000, "illegal2", SC ? 4'b0010 : 4'b1001, 0, 0);

      // Correction also applies with en low
      chk(0, 0, 0, 0, 1, 4'b0110, "load", 4'b0110, 0, 0);
      chk(0, 0, 0, 0, 0, 4'b0000, "illegal_en0", SC ? 4'b0001 : 4'b0110, 0, SC);

      // Illegal Johnson state (load also switches mode)
      chk(0, 0, 1, 0, 1, 4'b0110, "load_j", 4'b0110, 0, 0);
      chk(0, 0, 1, 0, 0, 4'b0000, "illegal_j", SC ? 4'b0000 : 4'b0110, 0, SC);

      // Randomized phase against the model
      cur_mode = 1'b1;
      for (int n = 0; n < 600; n++) begin
         logic r, l, e, d;
         logic [W-1:0] lv;
         r  = ($urandom_range(99) < 2);
         l  = ($urandom_range(99) < 10);
         e  = ($urandom_range(99) < 80);
         d  = 1'($urandom_range(1));
         lv = W'($urandom_range(MASK));
         if ($urandom_range(99) < 6) cur_mode = ~cur_mode;
         drive(r, e, cur_mode, d, l, lv, "random", 1'b0, '0, 1'b0, 1'b0);
      end

      // Let the monitor drain, bounded
      t = 0;
      while (sb.size() > 0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
